idu_issue_queue: RTL and testbench

//  Parametrised decoded-instruction buffer between ID1 and ID2; successor to the fixed single-packet ID2 hand-off.

---
 rtl/idu_issue_queue_pkg.sv | 39 +++
 rtl/idu_issue_queue_pair_check.sv | 25 ++
 rtl/idu_issue_queue.sv | 127 ++++++++++++
 tb/tb_idu_issue_queue.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idu_issue_queue_pkg.sv
// Package for the ID1->ID2 decoded-instruction issue queue.
// Holds the per-packet sideband layout (register fields and class bits) and
// a helper that extracts one packet's sideband from the 2-wide input buses.
package idu_issue_queue_pkg;

  localparam int unsigned PAYLOAD_W_DEF = 96;
  localparam int unsigned REG_W         = 5;

  // Sideband kept next to the opaque payload of every queue entry
  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             w_reg_ena;
    logic [REG_W-1:0] w_reg_dst;
    logic             is_ls;
    logic             is_ctrl;
  } side_t;

  // k = 0 selects the older packet (low half), k = 1 the younger one
  function automatic side_t slot_side(
    input logic [2*REG_W-1:0] rs,
    input logic [2*REG_W-1:0] rt,
    input logic [1:0]         w_reg_ena,
    input logic [2*REG_W-1:0] w_reg_dst,
    input logic [1:0]         is_ls,
    input logic [1:0]         is_ctrl,
    input logic               k
  );
    side_t s;
    s.rs        = k ? rs[2*REG_W-1:REG_W]        : rs[REG_W-1:0];
    s.rt        = k ? rt[2*REG_W-1:REG_W]        : rt[REG_W-1:0];
    s.w_reg_ena = k ? w_reg_ena[1]               : w_reg_ena[0];
    s.w_reg_dst = k ? w_reg_dst[2*REG_W-1:REG_W] : w_reg_dst[REG_W-1:0];
    s.is_ls     = k ? is_ls[1]                   : is_ls[0];
    s.is_ctrl   = k ? is_ctrl[1]                 : is_ctrl[0];
    return s;
  endfunction

endpackage

// File: rtl/idu_issue_queue_pair_check.sv
// idu_pair_check: decides whether the two oldest packets may issue together.
//   s0      in   master-slot sideband (older packet)
//   s1      in   slave-slot sideband (younger packet)
//   pair_ok out  1 when no RAW, WAW, memory-port or slave-control conflict
module idu_pair_check
  import idu_issue_queue_pkg::*;
(
  input  side_t s0,
  input  side_t s1,
  output logic  pair_ok
);

  logic raw, waw, ls_conflict, ctrl_conflict;

  always_comb begin
    raw           = s0.w_reg_ena && (s0.w_reg_dst != '0) &&
                    ((s0.w_reg_dst == s1.rs) || (s0.w_reg_dst == s1.rt));
    waw           = s0.w_reg_ena && s1.w_reg_ena &&
                    (s0.w_reg_dst == s1.w_reg_dst) && (s0.w_reg_dst != '0);
    ls_conflict   = s0.is_ls && s1.is_ls;
    ctrl_conflict = s1.is_ctrl;
    pair_ok       = !(raw || waw || ls_conflict || ctrl_conflict);
  end

endmodule

// File: rtl/idu_issue_queue.sv
// idu_issue_queue: circular buffer of decoded packets between ID1 and ID2.
//   clk, rst            clock, asynchronous active-high reset
//   flush               drop every queued entry (and any same-cycle push)
//   in_valid/in_*       up to two packets per cycle from ID1, [0] = older
//   in_ready            at least two free entries (from pre-pop occupancy)
//   out_valid/out_*     head (slot0, master) and head+1 (slot1, slave)
//   out_ready           ID2 takes every valid slot this cycle
//   count               occupancy
//   pair_block          master issues alone although two entries are queued
module idu_issue_queue
  import idu_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned PAYLOAD_W   = PAYLOAD_W_DEF,
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned DS_PAIR     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [1:0]             in_valid,
  input  logic [2*PAYLOAD_W-1:0] in_payload,
  input  logic [2*REG_W-1:0]     in_rs,
  input  logic [2*REG_W-1:0]     in_rt,
  input  logic [1:0]             in_w_reg_ena,
  input  logic [2*REG_W-1:0]     in_w_reg_dst,
  input  logic [1:0]             in_is_ls,
  input  logic [1:0]             in_is_ctrl,
  output logic                   in_ready,
  output logic [1:0]             out_valid,
  output logic [2*PAYLOAD_W-1:0] out_payload,
  output logic [2*REG_W-1:0]     out_rs,
  output logic [2*REG_W-1:0]     out_rt,
  output logic [1:0]             out_w_reg_ena,
  output logic [2*REG_W-1:0]     out_w_reg_dst,
  output logic [1:0]             out_is_ls,
  output logic [1:0]             out_is_ctrl,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   pair_block
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PAYLOAD_W-1:0] pay_mem  [DEPTH];
  side_t                side_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_1, rd_ptr_1;
  logic [CNT_W-1:0] count_q;
  side_t            s0, s1, in_s0, in_s1;
  logic             pair_ok, push, has1, has2, slave_ok, ds_hold;
  logic [1:0]       n_push, n_pop;

  assign wr_ptr_1 = wr_ptr + 1'b1;
  assign rd_ptr_1 = rd_ptr + 1'b1;
  assign s0       = side_mem[rd_ptr];
  assign s1       = side_mem[rd_ptr_1];
  assign in_s0    = slot_side(in_rs, in_rt, in_w_reg_ena, in_w_reg_dst, in_is_ls, in_is_ctrl, 1'b0);
  assign in_s1    = slot_side(in_rs, in_rt, in_w_reg_ena, in_w_reg_dst, in_is_ls, in_is_ctrl, 1'b1);

  idu_pair_check u_pair_check (
    .s0      (s0),
    .s1      (s1),
    .pair_ok (pair_ok)
  );

  always_comb begin
    in_ready = (count_q <= CNT_W'(DEPTH - 2));
    push     = in_valid[0] && in_ready;
    has1     = (count_q != '0);
    has2     = (count_q >= CNT_W'(2));
    slave_ok = (ISSUE_WIDTH == 2) && has2 && pair_ok;
    // A control transfer holds until its delay slot can issue beside it.
    // Single-issue builds have no slave slot, so the hold would never release.
    ds_hold  = (ISSUE_WIDTH == 2) && (DS_PAIR != 0) && s0.is_ctrl && !slave_ok;
    out_valid[0] = has1 && !ds_hold;
    out_valid[1] = slave_ok;
    pair_block   = out_valid[0] && !out_valid[1] && has2;
    n_push = push ? (in_valid[1] ? 2'd2 : 2'd1) : 2'd0;
    n_pop  = out_ready ? ({1'b0, out_valid[0]} + {1'b0, out_valid[1]}) : 2'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= wr_ptr;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PTR_W'(n_push);
      rd_ptr  <= rd_ptr + PTR_W'(n_pop);
      count_q <= count_q + CNT_W'(n_push) - CNT_W'(n_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pay_mem[wr_ptr]  <= in_payload[PAYLOAD_W-1:0];
      side_mem[wr_ptr] <= in_s0;
      if (in_valid[1]) begin
        pay_mem[wr_ptr_1]  <= in_payload[2*PAYLOAD_W-1:PAYLOAD_W];
        side_mem[wr_ptr_1] <= in_s1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= CNT_W'(DEPTH));
      if ((DS_PAIR != 0) && (ISSUE_WIDTH == 2) && has2)
        assert (!(s0.is_ctrl && s1.is_ctrl));
    end
  end

  assign count         = count_q;
  assign out_payload   = {pay_mem[rd_ptr_1], pay_mem[rd_ptr]};
  assign out_rs        = {s1.rs, s0.rs};
  assign out_rt        = {s1.rt, s0.rt};
  assign out_w_reg_ena = {s1.w_reg_ena, s0.w_reg_ena};
  assign out_w_reg_dst = {s1.w_reg_dst, s0.w_reg_dst};
  assign out_is_ls     = {s1.is_ls, s0.is_ls};
  assign out_is_ctrl   = {s1.is_ctrl, s0.is_ctrl};

endmodule

// File: tb/tb_idu_issue_queue.sv
module tb_idu_issue_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 96;

  typedef struct {
    logic [PW-1:0] pay;
    logic [4:0]    rs, rt, dst;
    logic          wen, ls, ctrl;
  } pkt_t;

  logic          clk = 1'b0;
  logic          rst, flush, out_ready;
  logic [1:0]    in_valid;
  logic [2*PW-1:0] in_payload;
  logic [9:0]    in_rs, in_rt, in_w_reg_dst;
  logic [1:0]    in_w_reg_ena, in_is_ls, in_is_ctrl;

  logic          in_ready, pair_block;
  logic [1:0]    out_valid, out_w_reg_ena, out_is_ls, out_is_ctrl;
  logic [2*PW-1:0] out_payload;
  logic [9:0]    out_rs, out_rt, out_w_reg_dst;
  logic [3:0]    count;

  logic          s_in_ready, s_pair_block;
  logic [1:0]    s_valid, s_w_reg_ena, s_is_ls, s_is_ctrl;
  logic [2*PW-1:0] s_payload;
  logic [9:0]    s_rs, s_rt, s_w_reg_dst;
  logic [3:0]    s_count;

  int   n_asserts = 0;
  int   n_fail    = 0;
  pkt_t q2[$];
  pkt_t q1[$];
  int unsigned dst_ctr = 0;
  pkt_t idle;

  always #5 clk = ~clk;

  idu_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .ISSUE_WIDTH(2), .DS_PAIR(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_payload(in_payload),
    .in_rs(in_rs), .in_rt(in_rt), .in_w_reg_ena(in_w_reg_ena), .in_w_reg_dst(in_w_reg_dst),
    .in_is_ls(in_is_ls), .in_is_ctrl(in_is_ctrl), .in_ready(in_ready), .out_valid(out_valid),
    .out_payload(out_payload), .out_rs(out_rs), .out_rt(out_rt), .out_w_reg_ena(out_w_reg_ena),
    .out_w_reg_dst(out_w_reg_dst), .out_is_ls(out_is_ls), .out_is_ctrl(out_is_ctrl),
    .out_ready(out_ready), .count(count), .pair_block(pair_block)
  );

  idu_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .ISSUE_WIDTH(1), .DS_PAIR(1)) dut_single (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_payload(in_payload),
    .in_rs(in_rs), .in_rt(in_rt), .in_w_reg_ena(in_w_reg_ena), .in_w_reg_dst(in_w_reg_dst),
    .in_is_ls(in_is_ls), .in_is_ctrl(in_is_ctrl), .in_ready(s_in_ready), .out_valid(s_valid),
    .out_payload(s_payload), .out_rs(s_rs), .out_rt(s_rt), .out_w_reg_ena(s_w_reg_ena),
    .out_w_reg_dst(s_w_reg_dst), .out_is_ls(s_is_ls), .out_is_ctrl(s_is_ctrl),
    .out_ready(out_ready), .count(s_count), .pair_block(s_pair_block)
  );

  function automatic pkt_t mk(input int rs, input int rt, input int wen, input int dst,
                              input int ls, input int ctrl);
    pkt_t p;
    p.pay  = {$urandom, $urandom, $urandom};
    p.rs   = 5'(rs);
    p.rt   = 5'(rt);
    p.wen  = (wen != 0);
    p.dst  = 5'(dst);
    p.ls   = (ls != 0);
    p.ctrl = (ctrl != 0);
    return p;
  endfunction

  // independent ALU op writing a fresh register each call
  function automatic pkt_t alu();
    dst_ctr = dst_ctr % 31 + 1;
    return mk(0, 0, 1, int'(dst_ctr), 0, 0);
  endfunction

  function automatic pkt_t rnd_pkt(input bit no_ctrl);
    pkt_t p;
    p = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 3) == 0), 0);
    if (!no_ctrl && $urandom_range(0, 5) == 0) begin
      p.ctrl = 1'b1;
      p.wen  = 1'b0;
      p.ls   = 1'b0;
    end
    return p;
  endfunction

  // Issue rules stated directly on the two oldest queued packets
  function automatic bit may_pair(input pkt_t a, input pkt_t b);
    if (a.wen && a.dst != 0 && (a.dst == b.rs || a.dst == b.rt)) return 1'b0;
    if (a.wen && b.wen && a.dst == b.dst && a.dst != 0) return 1'b0;
    if (a.ls && b.ls) return 1'b0;
    if (b.ctrl) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [1:0] exp_valid(input pkt_t q[$], input int iw);
    if (q.size() == 0) return 2'b00;
    if (iw == 2 && q.size() >= 2 && may_pair(q[0], q[1])) return 2'b11;
    if (iw == 2 && q[0].ctrl) return 2'b00;
    return 2'b01;
  endfunction

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [1:0] e2, e1;
    e2 = exp_valid(q2, 2);
    e1 = exp_valid(q1, 1);
    check("valid", PW'(out_valid), PW'(e2));
    check("count", PW'(count), PW'(q2.size()));
    check("in_ready", PW'(in_ready), PW'(q2.size() <= int'(DEPTH) - 2));
    check("pair_block", PW'(pair_block), PW'(e2 == 2'b01 && q2.size() >= 2));
    if (e2[0]) begin
      check("slot0_payload", out_payload[PW-1:0], q2[0].pay);
      check("slot0_side", PW'({out_rs[4:0], out_rt[4:0], out_w_reg_dst[4:0], out_w_reg_ena[0],
                               out_is_ls[0], out_is_ctrl[0]}),
            PW'({q2[0].rs, q2[0].rt, q2[0].dst, q2[0].wen, q2[0].ls, q2[0].ctrl}));
    end
    if (e2[1]) begin
      check("slot1_payload", out_payload[2*PW-1:PW], q2[1].pay);
      check("slot1_side", PW'({out_rs[9:5], out_rt[9:5], out_w_reg_dst[9:5], out_w_reg_ena[1],
                               out_is_ls[1], out_is_ctrl[1]}),
            PW'({q2[1].rs, q2[1].rt, q2[1].dst, q2[1].wen, q2[1].ls, q2[1].ctrl}));
    end
    check("single_valid", PW'(s_valid), PW'(e1));
    check("single_slave_off", PW'(s_valid[1]), PW'(1'b0));
    check("single_count", PW'(s_count), PW'(q1.size()));
    if (e1[0]) check("single_payload", s_payload[PW-1:0], q1[0].pay);
  endtask

  task automatic model_step(input int iw, input pkt_t a, input pkt_t b, input logic [1:0] v,
                            input logic rdy, input logic fl);
    pkt_t q[$];
    logic [1:0] ov;
    bit acc;
    if (iw == 2) q = q2; else q = q1;
    ov  = exp_valid(q, iw);
    acc = v[0] && (int'(DEPTH) - q.size() >= 2);
    if (fl) q.delete();
    else begin
      if (rdy && ov[0]) void'(q.pop_front());
      if (rdy && ov[1]) void'(q.pop_front());
      if (acc) begin
        q.push_back(a);
        if (v[1]) q.push_back(b);
      end
    end
    if (iw == 2) q2 = q; else q1 = q;
  endtask

  // called just after a falling edge: apply inputs, advance one cycle, check
  task automatic drive(input pkt_t a, input pkt_t b, input logic [1:0] v,
                       input logic rdy, input logic fl);
    in_valid     = v;
    in_payload   = {b.pay, a.pay};
    in_rs        = {b.rs, a.rs};
    in_rt        = {b.rt, a.rt};
    in_w_reg_ena = {b.wen, a.wen};
    in_w_reg_dst = {b.dst, a.dst};
    in_is_ls     = {b.ls, a.ls};
    in_is_ctrl   = {b.ctrl, a.ctrl};
    out_ready    = rdy;
    flush        = fl;
    model_step(2, a, b, v, rdy, fl);
    model_step(1, a, b, v, rdy, fl);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bit last_ctrl;
    idle = mk(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    in_valid = 2'b00;
    in_payload = '0;
    in_rs = '0; in_rt = '0; in_w_reg_dst = '0;
    in_w_reg_ena = '0; in_is_ls = '0; in_is_ctrl = '0;
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // independent pair issues dual
    drive(mk(2, 0, 1, 1, 0, 0), mk(4, 0, 1, 3, 0, 0), 2'b11, 1'b0, 1'b0);
    check("t1_valid", PW'(out_valid), PW'(2'b11));
    check("t1_count", PW'(count), PW'(2));
    drive(idle, idle, 2'b00, 1'b1, 1'b0);
    check("t1_drained", PW'(count), PW'(0));

    // RAW pair: master alone, then slave alone
    drive(mk(2, 3, 1, 1, 0, 0), mk(1, 4, 1, 5, 0, 0), 2'b11, 1'b0, 1'b0);
    check("t2_valid", PW'(out_valid), PW'(2'b01));
    check("t2_pair_block", PW'(pair_block), PW'(1'b1));
    drive(idle, idle, 2'b00, 1'b1, 1'b0);
    check("t2_slave_alone", PW'(out_valid), PW'(2'b01));
    drive(idle, idle, 2'b00, 1'b1, 1'b0);

    // fill, back-pressure, steady push+pop with pointer wrap
    repeat (3) drive(alu(), alu(), 2'b11, 1'b0, 1'b0);
    drive(alu(), alu(), 2'b11, 1'b0, 1'b0);
    check("t3_ready_full", PW'(in_ready), PW'(1'b0));
    drive(idle, idle, 2'b00, 1'b1, 1'b0);
    drive(alu(), idle, 2'b01, 1'b0, 1'b0);
    check("t3_ready_7", PW'(in_ready), PW'(1'b0));
    drive(alu(), alu(), 2'b11, 1'b1, 1'b0);
    check("t3_reject_at_7", PW'(count), PW'(5));
    drive(alu(), idle, 2'b01, 1'b0, 1'b0);
    repeat (4) begin
      drive(alu(), alu(), 2'b11, 1'b1, 1'b0);
      check("t3_steady", PW'(count), PW'(6));
    end
    repeat (6) drive(idle, idle, 2'b00, 1'b1, 1'b0);

    // branch waits for its delay slot
    drive(mk(1, 2, 0, 0, 0, 1), idle, 2'b01, 1'b1, 1'b0);
    repeat (3) begin
      drive(idle, idle, 2'b00, 1'b1, 1'b0);
      check("t4_branch_held", PW'(out_valid), PW'(2'b00));
    end
    drive(mk(3, 4, 1, 5, 0, 0), idle, 2'b01, 1'b0, 1'b0);
    check("t4_with_slot", PW'(out_valid), PW'(2'b11));
    repeat (2) drive(idle, idle, 2'b00, 1'b1, 1'b0);

    // flush beats a same-cycle push
    drive(alu(), alu(), 2'b11, 1'b0, 1'b0);
    drive(alu(), alu(), 2'b11, 1'b0, 1'b0);
    drive(alu(), idle, 2'b01, 1'b0, 1'b0);
    check("t5_count5", PW'(count), PW'(5));
    drive(alu(), alu(), 2'b11, 1'b1, 1'b1);
    check("t5_flushed", PW'(count), PW'(0));
    check("t5_no_valid", PW'(out_valid), PW'(2'b00));
    repeat (2) drive(idle, idle, 2'b00, 1'b1, 1'b0);
    drive(alu(), alu(), 2'b11, 1'b0, 1'b0);
    drive(idle, idle, 2'b00, 1'b1, 1'b0);

    // load + store share one memory port
    drive(mk(29, 0, 1, 8, 1, 0), mk(29, 9, 0, 0, 1, 0), 2'b11, 1'b0, 1'b0);
    check("t6_ls_single", PW'(out_valid), PW'(2'b01));
    repeat (2) drive(idle, idle, 2'b00, 1'b1, 1'b0);

    // asynchronous reset while occupied
    drive(alu(), alu(), 2'b11, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_count", PW'(count), PW'(0));
    check("rst_async_valid", PW'(out_valid), PW'(2'b00));
    q2.delete();
    q1.delete();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // random traffic; a branch is always followed by a non-branch
    last_ctrl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      pkt_t a, b;
      logic [1:0] v;
      logic rdy, fl;
      a = rnd_pkt(last_ctrl);
      b = rnd_pkt(a.ctrl);
      v[0] = ($urandom_range(0, 3) != 0);
      v[1] = v[0] && ($urandom_range(0, 1) != 0);
      fl   = ($urandom_range(0, 24) == 0);
      rdy  = ($urandom_range(0, 3) != 0);
      if (v[0] && !fl && q2.size() <= int'(DEPTH) - 2)
        last_ctrl = v[1] ? b.ctrl : a.ctrl;
      drive(a, b, v, rdy, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
